// File: rtl/gradient_bram_loader.sv
// rtl/gradient_bram_loader.sv - AXIS X/Y/Z gradient samples to AD5780 write commands in three BRAMs
// Optional saturation of input samples: define GRADIENT_LOADER_CLAMP_EN.
module gradient_bram_loader #(
  parameter int BRAM_DATA_WIDTH = 32,
  parameter int BRAM_ADDR_WIDTH = 10,
  parameter int SAMPLE_WIDTH    = 18
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [BRAM_ADDR_WIDTH-1:0]   cfg_length,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         frame_error,
  output logic [BRAM_ADDR_WIDTH-1:0]   sts_data,
  input  logic [31:0]                  s_axis_tdata,
  input  logic                         s_axis_tvalid,
  input  logic                         s_axis_tlast,
  output logic                         s_axis_tready,
  output logic                         bram_portx_clk,
  output logic                         bram_portx_rst,
  output logic [BRAM_ADDR_WIDTH-1:0]   bram_portx_addr,
  output logic [BRAM_DATA_WIDTH-1:0]   bram_portx_wrdata,
  output logic [BRAM_DATA_WIDTH/8-1:0] bram_portx_we,
  output logic                         bram_porty_clk,
  output logic                         bram_porty_rst,
  output logic [BRAM_ADDR_WIDTH-1:0]   bram_porty_addr,
  output logic [BRAM_DATA_WIDTH-1:0]   bram_porty_wrdata,
  output logic [BRAM_DATA_WIDTH/8-1:0] bram_porty_we,
  output logic                         bram_portz_clk,
  output logic                         bram_portz_rst,
  output logic [BRAM_ADDR_WIDTH-1:0]   bram_portz_addr,
  output logic [BRAM_DATA_WIDTH-1:0]   bram_portz_wrdata,
  output logic [BRAM_DATA_WIDTH/8-1:0] bram_portz_we
);

  localparam int WE_WIDTH = BRAM_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_ACC_X, S_ACC_Y, S_ACC_Z, S_WRITE, S_DONE
  } state_t;

  state_t state, state_next;

  logic [BRAM_ADDR_WIDTH-1:0] len_q;
  logic [BRAM_ADDR_WIDTH-1:0] frame_cnt;
  logic [BRAM_ADDR_WIDTH-1:0] frame_cnt_inc;
  logic [BRAM_DATA_WIDTH-1:0] x_word, y_word, z_word;
  logic                       z_last;
  logic                       err_q;
  logic                       handshake;
  logic                       start_ok;
  logic [SAMPLE_WIDTH-1:0]    code;
  logic                       tready_c, busy_c, done_c, we_c;

  assign handshake     = s_axis_tvalid && s_axis_tready;
  assign start_ok      = start && (state == S_IDLE || state == S_DONE);
  assign frame_cnt_inc = frame_cnt + 1'b1;

`ifdef GRADIENT_LOADER_CLAMP_EN
  localparam logic signed [31:0] CODE_MAX = (32'sd1 <<< (SAMPLE_WIDTH - 1)) - 32'sd1;
  localparam logic signed [31:0] CODE_MIN = -(32'sd1 <<< (SAMPLE_WIDTH - 1));

  always_comb begin
    code = s_axis_tdata[SAMPLE_WIDTH-1:0];
    if ($signed(s_axis_tdata) > CODE_MAX)
      code = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    else if ($signed(s_axis_tdata) < CODE_MIN)
      code = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
  end
`else
  logic tdata_hi_unused;
  assign tdata_hi_unused = ^s_axis_tdata[31:SAMPLE_WIDTH];
  assign code            = s_axis_tdata[SAMPLE_WIDTH-1:0];
`endif

  // AD5780 frame: 0001 selects the DAC register, code sits in bits [19:2]
  function automatic logic [BRAM_DATA_WIDTH-1:0] fmt_cmd(input logic [SAMPLE_WIDTH-1:0] c);
    fmt_cmd = '0;
    fmt_cmd[SAMPLE_WIDTH+5:0] = {4'b0001, c, 2'b00};
  endfunction

  always_ff @(posedge aclk) begin
    if (areset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_next = (cfg_length == '0) ? S_DONE : S_ACC_X;
      end
      S_ACC_X: if (handshake) state_next = s_axis_tlast ? S_DONE : S_ACC_Y;
      S_ACC_Y: if (handshake) state_next = s_axis_tlast ? S_DONE : S_ACC_Z;
      S_ACC_Z: if (handshake) state_next = S_WRITE;
      S_WRITE: state_next = (frame_cnt_inc == len_q || z_last) ? S_DONE : S_ACC_X;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    tready_c = 1'b0;
    busy_c   = 1'b0;
    done_c   = 1'b0;
    we_c     = 1'b0;
    case (state)
      S_ACC_X, S_ACC_Y, S_ACC_Z: begin
        tready_c = 1'b1;
        busy_c   = 1'b1;
      end
      S_WRITE: begin
        busy_c = 1'b1;
        we_c   = 1'b1;
      end
      S_DONE:  done_c = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      len_q     <= '0;
      frame_cnt <= '0;
      x_word    <= '0;
      y_word    <= '0;
      z_word    <= '0;
      z_last    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (start_ok) begin
        len_q     <= cfg_length;
        frame_cnt <= '0;
        err_q     <= 1'b0;
      end
      if (handshake) begin
        case (state)
          S_ACC_X: begin
            x_word <= fmt_cmd(code);
            if (s_axis_tlast) err_q <= 1'b1;
          end
          S_ACC_Y: begin
            y_word <= fmt_cmd(code);
            if (s_axis_tlast) err_q <= 1'b1;
          end
          S_ACC_Z: begin
            z_word <= fmt_cmd(code);
            z_last <= s_axis_tlast;
          end
          default: ;
        endcase
      end
      if (state == S_WRITE) frame_cnt <= frame_cnt_inc;
    end
  end

  assign s_axis_tready = tready_c;
  assign busy          = busy_c;
  assign done          = done_c;
  assign frame_error   = err_q;
  assign sts_data      = frame_cnt;

  assign bram_portx_clk    = aclk;
  assign bram_porty_clk    = aclk;
  assign bram_portz_clk    = aclk;
  assign bram_portx_rst    = areset;
  assign bram_porty_rst    = areset;
  assign bram_portz_rst    = areset;
  assign bram_portx_addr   = frame_cnt;
  assign bram_porty_addr   = frame_cnt;
  assign bram_portz_addr   = frame_cnt;
  assign bram_portx_wrdata = x_word;
  assign bram_porty_wrdata = y_word;
  assign bram_portz_wrdata = z_word;
  assign bram_portx_we     = {WE_WIDTH{we_c}};
  assign bram_porty_we     = {WE_WIDTH{we_c}};
  assign bram_portz_we     = {WE_WIDTH{we_c}};

endmodule
